// File: rtl/alu_seq_driver.sv
// alu_seq_driver: sequences an external combinational ALU to run single ops or a shift-and-add multiply.
// Ports: clk/rst_n (async active-low); req_valid/req_ready/req_op/req_a/req_b command channel;
//   rsp_valid/rsp_ready/rsp_result/rsp_zero/rsp_err response channel;
//   alu_src1/alu_src2/alu_op drive the ALU, alu_result/alu_zero come back from it.
// Option: define MUL_EARLY_EXIT_EN to end a multiply once the remaining multiplier bits are all zero.
module alu_seq_driver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, EXEC, ADD, SHIFT, DONE} state_t;

  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplr_q, mplr_d, res_q, res_d;
  logic [2:0] op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic vld_q, vld_d, zero_q, zero_d, err_q, err_d;
  logic unused;

  // zero flag from the ALU is reserved; the response flag is derived from the registered result
  assign unused = alu_zero;

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = vld_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;

  // mcand/mplr double as the captured a/b operands for single ops.
  // Paths that reach DONE from anything but EXEC spend one settle cycle in DONE before rsp_valid rises.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    vld_d    = vld_q;
    res_d    = res_q;
    zero_d   = zero_q;
    err_d    = err_q;
    alu_src1 = '0;
    alu_src2 = '0;
    alu_op   = 3'b000;
    case (state_q)
      IDLE: if (req_valid) begin
        mcand_d = req_a;
        mplr_d  = req_b;
        op_d    = req_op[2:0];
        acc_d   = '0;
        cnt_d   = '0;
        err_d   = req_op[3] && (req_op[2:0] != 3'b000);
        state_d = !req_op[3] ? EXEC : err_d ? DONE : ADD;
        if (err_d) begin
          res_d  = '0;
          zero_d = 1'b1;
        end
      end
      EXEC: begin
        alu_src1 = mcand_q;
        alu_src2 = mplr_q;
        alu_op   = op_q;
        res_d    = alu_result;
        zero_d   = (alu_result == '0);
        vld_d    = 1'b1;
        state_d  = DONE;
      end
      ADD:
`ifdef MUL_EARLY_EXIT_EN
        if (mplr_q == '0) begin
          res_d   = acc_q;
          zero_d  = (acc_q == '0);
          state_d = DONE;
        end else
`endif
        begin
          alu_src1 = acc_q;
          alu_src2 = mcand_q;
          if (mplr_q[0]) acc_d = alu_result;
          state_d = SHIFT;
        end
      SHIFT: begin
        alu_src1 = mcand_q;
        alu_src2 = WIDTH'(1);
        alu_op   = 3'b110;
        mcand_d  = alu_result;
        mplr_d   = mplr_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        state_d  = (cnt_q == LAST) ? DONE : ADD;
        if (cnt_q == LAST) begin
          res_d  = acc_q;
          zero_d = (acc_q == '0);
        end
      end
      DONE: begin
        vld_d = 1'b1;
        if (vld_q && rsp_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_driver.sv
// tb_alu_seq_driver: scoreboard bench for alu_seq_driver with a behavioural ALU and reference model.
module tb_alu_seq_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       rsp_ready = 1'b1;
  logic [3:0] req_op = 4'd0;
  logic [7:0] req_a = 8'd0;
  logic [7:0] req_b = 8'd0;
  logic       req_ready, rsp_valid, rsp_zero, rsp_err, alu_zero;
  logic [7:0] rsp_result, alu_src1, alu_src2, alu_result;
  logic [2:0] alu_op;

  typedef struct {
    int         t;
    int         lat;
    int         pairs;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       zero;
    logic       err;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   md;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    case (op)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return x ^ y;
      3'd5: return {7'd0, x < y};
      3'd6: return x << y[2:0];
      default: return x >> y[2:0];
    endcase
  endfunction

  assign alu_result = alu_f(alu_op, alu_src1, alu_src2);
  assign alu_zero   = (alu_result == 8'd0);

  alu_seq_driver #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, expv, cyc);
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input int t);
    exp_t e;
    e.t = t; e.op = op; e.a = a; e.b = b;
    e.err = 1'b0; e.lat = 2; e.pairs = 0; e.res = 8'd0;
    if (!op[3]) e.res = alu_f(op[2:0], a, b);
    else if (op == 4'b1000) begin
      e.res = 8'(int'(a) * int'(b));
`ifdef MUL_EARLY_EXIT_EN
      begin
        int k;
        k = 0;
        while (k < 8 && (int'(b) >> k) != 0) k++;
        e.pairs = k;
        e.lat = (k < 8) ? 2 * k + 3 : 18;
      end
`else
      e.pairs = 8;
      e.lat = 18;
`endif
    end else e.err = 1'b1;
    e.zero = (e.res == 8'd0);
    return e;
  endfunction

  // expected {src1, src2, alu_op} d cycles after acceptance
  function automatic logic [18:0] exp_drive(input exp_t e, input int d);
    int j;
    logic [7:0] mc, acc;
    if (!e.op[3]) return (d == 1) ? {e.a, e.b, e.op[2:0]} : 19'd0;
    if (e.op != 4'b1000 || d < 1 || d > 2 * e.pairs) return 19'd0;
    j = (d - 1) / 2;
    mc = 8'(int'(e.a) << j);
    acc = 8'(int'(e.a) * (int'(e.b) & ((1 << j) - 1)));
    return (d % 2 == 1) ? {acc, mc, 3'b000} : {mc, 8'd1, 3'b110};
  endfunction

  initial forever begin
    @(negedge clk);
    #1;
    if (q.size() != 0 && cyc > q[0].t) begin
      me = q[0];
      md = cyc - me.t;
      chk("alu_drive", {alu_src1, alu_src2, alu_op}, exp_drive(me, md));
      chk("req_ready_busy", req_ready, 0);
      chk("rsp_valid", rsp_valid, md >= me.lat);
      if (md >= me.lat) begin
        chk("rsp_fields", {rsp_result, rsp_zero, rsp_err}, {me.res, me.zero, me.err});
        if (rsp_ready) void'(q.pop_front());
      end
      if (md > me.lat + 60) begin
        chk("rsp_timeout", md, me.lat);
        void'(q.pop_front());
      end
    end else begin
      chk("idle", {req_ready, rsp_valid, alu_src1, alu_src2, alu_op}, {1'b1, 20'd0});
    end
  end

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input int hold);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", n, 0);
    else begin
      q.push_back(model(op, a, b, cyc));
      rsp_ready = (hold == 0);
    end
    @(negedge clk);
    req_valid = 1'b0; req_op = 4'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
  endtask

  task automatic finish(input int hold);
    int n;
    n = 0;
    if (hold > 0) begin
      while (!rsp_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      repeat (hold) begin
        req_valid = 1'b1; req_op = 4'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
        @(negedge clk);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [3:0] op;
    logic [7:0] a, b;
    repeat (3) @(negedge clk);
    chk("reset_state", {req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, alu_src1, alu_src2, alu_op}, {1'b1, 30'd0});
    rst_n = 1'b1;
    issue(4'b0000, 8'd5, 8'd3, 0);   finish(0);
    issue(4'b0001, 8'd3, 8'd3, 0);   finish(0);
    issue(4'b0101, 8'd2, 8'd9, 0);   finish(0);
    issue(4'b1000, 8'd13, 8'd11, 0); finish(0);
    issue(4'b1000, 8'd20, 8'd20, 0); finish(0);
    issue(4'b1011, 8'd1, 8'd2, 0);   finish(0);
    issue(4'b0000, 8'd100, 8'd50, 5); finish(5);
    issue(4'b1000, 8'd7, 8'd3, 0);   finish(0);
    issue(4'b1000, 8'd9, 8'd0, 0);   finish(0);
    issue(4'b1000, 8'd255, 8'd255, 2); finish(2);
    for (int i = 0; i < 40; i++) begin
      int r, h;
      r = $urandom_range(0, 9);
      h = $urandom_range(0, 3);
      a = 8'($urandom);
      b = 8'($urandom);
      op = (r < 5) ? {1'b0, 3'($urandom)} : (r < 8) ? 4'b1000 : {1'b1, 3'($urandom_range(1, 7))};
      if (op == 4'b1000 && $urandom_range(0, 2) == 0) b = 8'($urandom_range(0, 15));
      issue(op, a, b, h);
      finish(h);
    end
    issue(4'b0000, 8'd10, 8'd20, 0); finish(0);
    issue(4'b1000, 8'd9, 8'd200, 0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("async_reset", {rsp_result, rsp_zero, rsp_err, rsp_valid, req_ready, alu_src1, alu_src2, alu_op}, {8'd0, 4'b0001, 19'd0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(4'b0000, 8'd1, 8'd1, 0); finish(0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
